calc_key_sequencer: RTL and testbench



---
 rtl/calc_pkg.sv | 36 +++
 rtl/dec_accum.sv | 32 +++
 rtl/calc_key_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_calc_key_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator: key codes, ALU op encoding, sequencer states.
package calc_pkg;

    localparam int unsigned WIDTH      = 20;
    localparam int unsigned MAX_DIGITS = 6;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_DIV = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_CLR = 4'd15;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_A,
        S_OP,
        S_B,
        S_RES
    } state_t;

    function automatic logic key_is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    function automatic logic key_is_op(input logic [3:0] code);
        return (code >= KEY_ADD) && (code <= KEY_DIV);
    endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal digit accumulator: val*10 + digit as shift-add, frozen once the digit limit is hit.
module dec_accum #(
    parameter int unsigned WIDTH      = 20,
    parameter int unsigned MAX_DIGITS = 6,
    parameter int unsigned CNT_W      = 3
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic [3:0]       digit_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [WIDTH-1:0] val_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic             full;
    logic [WIDTH-1:0] digit_ext;

    assign full      = (cnt_i == CNT_W'(MAX_DIGITS));
    assign digit_ext = {{(WIDTH-4){1'b0}}, digit_i};

    always_comb begin
        val_o = val_i;
        cnt_o = cnt_i;
        if (!full) begin
            val_o = (val_i << 3) + (val_i << 1) + digit_ext;
            // Leading zeros do not consume a digit slot.
            if ((val_i != '0) || (digit_i != 4'd0)) begin
                cnt_o = cnt_i + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/calc_key_sequencer.sv
// Key-event sequencer feeding the calculator ALU with A/B/op and latching results for display.
// Optional: define CALC_REPEAT_EQ_EN to make EQ in the result state re-apply the held op and B.
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH      = calc_pkg::WIDTH,
    parameter int unsigned MAX_DIGITS = calc_pkg::MAX_DIGITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    input  logic [WIDTH-1:0] alu_res,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [1:0]       op,
    output logic [WIDTH-1:0] disp,
    output logic             res_valid,
    output logic             err
);

    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, disp_q, disp_d;
    op_t              op_q, op_d;
    logic             res_valid_q, res_valid_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             is_digit, is_op, is_eq, is_clr;
    logic             div_zero, load_res;
    op_t              key_op;
    logic [WIDTH-1:0] digit_val;
    logic [WIDTH-1:0] acc_in, acc_val;
    logic [CNT_W-1:0] acc_cnt;

    assign is_digit  = key_is_digit(key_code);
    assign is_op     = key_is_op(key_code);
    assign is_eq     = (key_code == KEY_EQ);
    assign is_clr    = (key_code == KEY_CLR);
    // code-10 on the two low bits: 10..13 -> 00..11.
    assign key_op    = op_t'(key_code[1:0] + 2'd2);
    assign digit_val = {{(WIDTH-4){1'b0}}, key_code};
    assign div_zero  = (op_q == OP_DIV) && (b_q == '0);
    assign acc_in    = (state_q == S_B) ? b_q : a_q;

    dec_accum #(
        .WIDTH      (WIDTH),
        .MAX_DIGITS (MAX_DIGITS),
        .CNT_W      (CNT_W)
    ) u_dec_accum (
        .val_i   (acc_in),
        .digit_i (key_code),
        .cnt_i   (cnt_q),
        .val_o   (acc_val),
        .cnt_o   (acc_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_A;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_ADD;
            disp_q      <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            disp_q      <= disp_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (key_valid) begin
            if (is_clr) begin
                state_d = S_A;
            end else begin
                unique case (state_q)
                    S_A:   if (is_op) state_d = S_OP;
                    S_OP:  if (is_digit) state_d = S_B;
                    S_B: begin
                        // A divide-by-zero while chaining still lands in the result state.
                        if (is_eq || (is_op && div_zero)) state_d = S_RES;
                        else if (is_op)                   state_d = S_OP;
                    end
                    S_RES: begin
                        if (is_digit)   state_d = S_A;
                        else if (is_op) state_d = S_OP;
                    end
                endcase
            end
        end
    end

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        disp_d      = disp_q;
        res_valid_d = 1'b0;
        err_d       = err_q;
        cnt_d       = cnt_q;
        load_res    = 1'b0;
        if (key_valid) begin
            if (is_clr) begin
                a_d    = '0;
                b_d    = '0;
                op_d   = OP_ADD;
                disp_d = '0;
                err_d  = 1'b0;
                cnt_d  = '0;
            end else begin
                unique case (state_q)
                    S_A: begin
                        if (is_digit) begin
                            a_d    = acc_val;
                            cnt_d  = acc_cnt;
                            disp_d = acc_val;
                        end else if (is_op) begin
                            op_d  = key_op;
                            b_d   = '0;
                            cnt_d = '0;
                        end
                    end
                    S_OP: begin
                        if (is_digit) begin
                            b_d    = digit_val;
                            cnt_d  = CNT_W'(key_code != 4'd0);
                            disp_d = digit_val;
                        end else if (is_op) begin
                            op_d = key_op;
                        end
                    end
                    S_B: begin
                        if (is_digit) begin
                            b_d    = acc_val;
                            cnt_d  = acc_cnt;
                            disp_d = acc_val;
                        end else if (is_eq) begin
                            load_res = 1'b1;
                        end else if (is_op) begin
                            load_res = 1'b1;
                            op_d     = key_op;
                            b_d      = '0;
                            cnt_d    = '0;
                        end
                    end
                    S_RES: begin
                        if (is_digit) begin
                            a_d    = digit_val;
                            b_d    = '0;
                            err_d  = 1'b0;
                            cnt_d  = CNT_W'(key_code != 4'd0);
                            disp_d = digit_val;
                        end else if (is_op) begin
                            op_d  = key_op;
                            b_d   = '0;
                            err_d = 1'b0;
                            cnt_d = '0;
                        end else if (is_eq) begin
`ifdef CALC_REPEAT_EQ_EN
                            load_res = 1'b1;
`else
                            load_res = 1'b0;
`endif
                        end
                    end
                endcase
            end
        end
        if (load_res) begin
            res_valid_d = 1'b1;
            if (div_zero) begin
                err_d  = 1'b1;
                a_d    = '0;
                disp_d = '0;
            end else begin
                a_d    = alu_res;
                disp_d = alu_res;
            end
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign op        = op_q;
    assign disp      = disp_q;
    assign res_valid = res_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Self-checking bench: behavioural calculator model, per-cycle compare, directed and random keys.
module tb_calc_key_sequencer;
    import calc_pkg::*;

    localparam int M_A = 0, M_OP = 1, M_B = 2, M_RES = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             key_valid;
    logic [3:0]       key_code;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] A, B, disp;
    logic [1:0]       op;
    logic             res_valid, err;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    logic [WIDTH-1:0] ma, mb, mdisp;
    logic [1:0]       mop;
    logic             mrv, merr;
    int               mst;

    always #5 clk = ~clk;

    calc_key_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .alu_res   (alu_res),
        .A         (A),
        .B         (B),
        .op        (op),
        .disp      (disp),
        .res_valid (res_valid),
        .err       (err)
    );

    function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [1:0] o);
        case (o)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a * b;
            default: return (b == '0) ? '1 : a / b;
        endcase
    endfunction

    assign alu_res = alu_fn(A, B, op);

    function automatic int ndig(input logic [WIDTH-1:0] v);
        int unsigned x = v;
        int n = 0;
        while (x != 0) begin
            x = x / 10;
            n++;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ma = '0; mb = '0; mdisp = '0; mop = 2'd0; mrv = 1'b0; merr = 1'b0; mst = M_A;
    endtask

    task automatic model_result();
        logic [WIDTH-1:0] r;
        mrv = 1'b1;
        mst = M_RES;
        if (mop == 2'd3 && mb == '0) begin
            merr = 1'b1; ma = '0; mdisp = '0;
        end else begin
            r = alu_fn(ma, mb, mop);
            ma = r; mdisp = r;
        end
    endtask

    function automatic logic [WIDTH-1:0] append(input logic [WIDTH-1:0] v, input int d);
        int unsigned x = v;
        if (ndig(v) >= MAX_DIGITS) return v;
        x = x * 10 + d;
        return x[WIDTH-1:0];
    endfunction

    task automatic model_step(input logic v, input logic [3:0] c);
        int d = c;
        bit dz;
        mrv = 1'b0;
        if (!v) return;
        if (d == 15) begin
            model_reset();
            return;
        end
        case (mst)
            M_A: begin
                if (d <= 9) begin
                    ma = append(ma, d); mdisp = ma;
                end else if (d <= 13) begin
                    mop = 2'(d - 10); mb = '0; mst = M_OP;
                end
            end
            M_OP: begin
                if (d <= 9) begin
                    mb = WIDTH'(d); mdisp = mb; mst = M_B;
                end else if (d <= 13) begin
                    mop = 2'(d - 10);
                end
            end
            M_B: begin
                dz = (mop == 2'd3 && mb == '0);
                if (d <= 9) begin
                    mb = append(mb, d); mdisp = mb;
                end else if (d == 14) begin
                    model_result();
                end else if (d <= 13) begin
                    model_result();
                    mop = 2'(d - 10); mb = '0;
                    mst = dz ? M_RES : M_OP;
                end
            end
            default: begin
                if (d <= 9) begin
                    ma = WIDTH'(d); mb = '0; merr = 1'b0; mdisp = ma; mst = M_A;
                end else if (d <= 13) begin
                    mop = 2'(d - 10); mb = '0; merr = 1'b0; mst = M_OP;
                end else begin
`ifdef CALC_REPEAT_EQ_EN
                    model_result();
`endif
                end
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("A", 32'(A), 32'(ma));
            check("B", 32'(B), 32'(mb));
            check("op", 32'(op), 32'(mop));
            check("disp", 32'(disp), 32'(mdisp));
            check("res_valid", 32'(res_valid), 32'(mrv));
            check("err", 32'(err), 32'(merr));
        end
    end

    // One key (or idle) per clock: drive after the negedge compare, update model after the edge.
    task automatic step(input logic v, input logic [3:0] c);
        @(negedge clk);
        #1;
        key_valid = v;
        key_code  = c;
        @(posedge clk);
        #1;
        model_step(v, c);
        key_valid = 1'b0;
    endtask

    task automatic press(input logic [3:0] c);
        step(1'b1, c);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_A"}, 32'(A), 0);
        check({tag, "_B"}, 32'(B), 0);
        check({tag, "_op"}, 32'(op), 0);
        check({tag, "_disp"}, 32'(disp), 0);
        check({tag, "_rv"}, 32'(res_valid), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int rv_cnt;
        logic [3:0] c;
        rst = 1'b1;
        key_valid = 1'b0;
        key_code = 4'd0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1;

        // 123 + 321
        press(4'd1); press(4'd2); press(4'd3); press(KEY_ADD);
        press(4'd3); press(4'd2); press(4'd1);
        press(KEY_EQ);
        check("t1_disp", 32'(disp), 444);
        check("t1_A", 32'(A), 123 + 321);
        check("t1_B", 32'(B), 321);
        check("t1_op", 32'(op), 0);
        check("t1_rv", 32'(res_valid), 1);
        step(1'b0, 4'd0);
        check("t1_rv_drop", 32'(res_valid), 0);
        press(KEY_CLR);

        // 36 * 17 chained into + 4
        press(4'd3); press(4'd6); press(KEY_MUL); press(4'd1); press(4'd7);
        press(KEY_ADD);
        check("t2_chain_disp", 32'(disp), 612);
        check("t2_chain_rv", 32'(res_valid), 1);
        press(4'd4); press(KEY_EQ);
        check("t2_disp", 32'(disp), 616);
        check("t2_op", 32'(op), 0);
        press(KEY_CLR);

        // 12 / 0
        press(4'd1); press(4'd2); press(KEY_DIV); press(4'd0); press(KEY_EQ);
        check("t3_err", 32'(err), 1);
        check("t3_disp", 32'(disp), 0);
        check("t3_rv", 32'(res_valid), 1);
        press(4'd5);
        check("t3_err_clr", 32'(err), 0);
        check("t3_A", 32'(A), 5);
        press(KEY_CLR);

        // digit limit and leading zeros
        for (int i = 1; i <= 7; i++) press(4'(i));
        check("t4_limit", 32'(A), 123456);
        press(KEY_CLR);
        press(4'd0); press(4'd0); press(4'd9);
        check("t4_lead0", 32'(A), 9);
        for (int i = 1; i <= 5; i++) press(4'(i));
        check("t4_lead0_limit", 32'(A), 912345);
        press(4'd7);
        check("t4_lead0_frozen", 32'(A), 912345);
        press(KEY_CLR);

        // CLR and async reset mid-entry
        press(4'd2); press(4'd8); press(KEY_SUB); press(4'd6);
        press(KEY_CLR);
        check_reset_outputs("clr");
        press(4'd4); press(4'd2); press(KEY_MUL); press(4'd3);
        pulse_rst();
        step(1'b0, 4'd0);
        check_reset_outputs("post_rst");

        // repeated EQ
        press(4'd5); press(KEY_ADD); press(4'd3); press(KEY_EQ);
        check("t6_first", 32'(disp), 8);
        rv_cnt = 0;
        press(KEY_EQ);
        rv_cnt += int'(res_valid);
        press(KEY_EQ);
        rv_cnt += int'(res_valid);
`ifdef CALC_REPEAT_EQ_EN
        check("t6_repeat_disp", 32'(disp), 14);
        check("t6_repeat_rv", 32'(rv_cnt), 2);
`else
        check("t6_repeat_disp", 32'(disp), 8);
        check("t6_repeat_rv", 32'(rv_cnt), 0);
`endif
        press(KEY_CLR);

        // random keys against the model
        for (int i = 0; i < 3000; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 55)      c = 4'($urandom_range(0, 9));
            else if (r < 62) c = 4'd0;
            else if (r < 82) c = 4'($urandom_range(10, 13));
            else if (r < 97) c = KEY_EQ;
            else             c = KEY_CLR;
            step(($urandom_range(0, 3) != 0), c);
            if ($urandom_range(0, 499) == 0) pulse_rst();
        end

        step(1'b0, 4'd0);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got 1 expected 0");
        $fatal(1);
    end

endmodule
